execute_responder: RTL and testbench

- Responder end of the VR16 control-unit handshake: executes one decoded instruction request at a time.
- Commits register-file writes and PC updates, then returns write_done / jump_done / pc_reset_done.
- Owns the 4x16 architectural register file and the 12-bit program counter.
- Sits between the control unit (requester) and fetch (consumer of pc).

---
 rtl/vr16_pkg.sv | 25 ++
 rtl/vr16_register_file.sv | 36 +++
 rtl/execute_responder.sv | 178 +++++++++++++++++
 tb/tb_execute_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vr16_pkg.sv
// Shared VR16 execute-side definitions.
// Widths, opcodes and responder FSM states.
package vr16_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int ADDR_WIDTH    = 12;
  localparam int REG_IDX_WIDTH = 2;
  localparam int NUM_REGS      = 2 ** REG_IDX_WIDTH;
  localparam int OP_WIDTH      = 4;
  localparam int IMM_WIDTH     = 8;

  localparam logic [OP_WIDTH-1:0] OP_ADD    = 4'b0000;
  localparam logic [OP_WIDTH-1:0] OP_STOREI = 4'b1000;
  localparam logic [OP_WIDTH-1:0] OP_JUMP   = 4'b1001;
  localparam logic [OP_WIDTH-1:0] OP_DELETE = 4'b1010;
  localparam logic [OP_WIDTH-1:0] OP_HALT   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RELEASE,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/vr16_register_file.sv
// VR16 architectural register file.
// One sync write port, two comb read ports.
module vr16_register_file
  import vr16_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [REG_IDX_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [REG_IDX_WIDTH-1:0] raddr_a_i,
  input  logic [REG_IDX_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0]    rdata_a_o,
  output logic [DATA_WIDTH-1:0]    rdata_b_o
);

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];

  // Storage: cleared on reset, single write per edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see pre-edge contents, no bypass
  always_comb begin
    rdata_a_o = rf_q[raddr_a_i];
    rdata_b_o = rf_q[raddr_b_i];
  end

endmodule

// File: rtl/execute_responder.sv
// VR16 execute responder: runs one request.
// Commits rf/pc writes and returns done pulses.
module execute_responder
  import vr16_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [OP_WIDTH-1:0]      req_opcode,
  input  logic [REG_IDX_WIDTH-1:0] store_at,
  input  logic [REG_IDX_WIDTH-1:0] reg_to_work_on,
  input  logic [IMM_WIDTH-1:0]     eight_bit_imm_val,
  input  logic [ADDR_WIDTH-1:0]    jump_address_input,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     increment_ins_count,
  input  logic [REG_IDX_WIDTH-1:0] rd_addr_a,
  input  logic [REG_IDX_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0]    rd_data_a,
  output logic [DATA_WIDTH-1:0]    rd_data_b,
  output logic [ADDR_WIDTH-1:0]    pc,
  output logic                     write_done,
  output logic                     jump_done,
  output logic                     pc_reset_done,
  output logic                     illegal_op,
  output logic                     halted
);

  state_e                   state_q, state_d;
  logic [OP_WIDTH-1:0]      op_q;
  logic [REG_IDX_WIDTH-1:0] dst_q;
  logic [REG_IDX_WIDTH-1:0] del_q;
  logic [IMM_WIDTH-1:0]     imm_q;
  logic [ADDR_WIDTH-1:0]    jaddr_q;
  logic [DATA_WIDTH-1:0]    alu_q;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic                     inc_prev_q;
  logic                     wd_q, wd_d;
  logic                     jd_q, jd_d;
  logic                     prd_q, prd_d;
  logic                     ill_q, ill_d;
  logic                     halted_q, halted_d;
  logic                     latch_en;
  logic                     inc_rise;
  logic                     rf_we;
  logic [REG_IDX_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]    rf_wdata;

  assign inc_rise = increment_ins_count & ~inc_prev_q;

  vr16_register_file u_rf (
    .clk       (clk),
    .reset     (reset),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rd_addr_a),
    .raddr_b_i (rd_addr_b),
    .rdata_a_o (rd_data_a),
    .rdata_b_o (rd_data_b)
  );

  // Next state, commit decode and pc arbitration
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = dst_q;
    rf_wdata = alu_q;
    pc_d     = pc_q;
    jd_d     = 1'b0;
    prd_d    = 1'b0;
    ill_d    = 1'b0;
    halted_d = halted_q;
    if (inc_rise && state_q != ST_HALTED) begin
      pc_d = pc_q + 12'd1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          latch_en = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RELEASE;
        case (op_q)
          OP_ADD: begin
            rf_we = 1'b1;
          end
          OP_STOREI: begin
            rf_we    = 1'b1;
            rf_wdata = {8'h00, imm_q};
          end
          OP_DELETE: begin
            rf_we    = 1'b1;
            rf_waddr = del_q;
            rf_wdata = '0;
          end
          OP_JUMP: begin
            pc_d = jaddr_q;
            jd_d = 1'b1;
          end
          OP_HALT: begin
            pc_d     = '0;
            prd_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end
          default: begin
            ill_d = 1'b1;
          end
        endcase
      end
      ST_RELEASE: begin
        if (!req_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    wd_d = rf_we;
  end

  // Control state, pc and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      inc_prev_q <= 1'b0;
      wd_q       <= 1'b0;
      jd_q       <= 1'b0;
      prd_q      <= 1'b0;
      ill_q      <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inc_prev_q <= increment_ins_count;
      wd_q       <= wd_d;
      jd_q       <= jd_d;
      prd_q      <= prd_d;
      ill_q      <= ill_d;
      halted_q   <= halted_d;
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      dst_q   <= '0;
      del_q   <= '0;
      imm_q   <= '0;
      jaddr_q <= '0;
      alu_q   <= '0;
    end else if (latch_en) begin
      op_q    <= req_opcode;
      dst_q   <= store_at;
      del_q   <= reg_to_work_on;
      imm_q   <= eight_bit_imm_val;
      jaddr_q <= jump_address_input;
      alu_q   <= alu_result;
    end
  end

  assign pc            = pc_q;
  assign write_done    = wd_q;
  assign jump_done     = jd_q;
  assign pc_reset_done = prd_q;
  assign illegal_op    = ill_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_execute_responder.sv
// Bench for execute_responder.
// Vector table plus multi-cycle corner sequences.
module tb_execute_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_opcode;
  logic [1:0]  store_at;
  logic [1:0]  reg_to_work_on;
  logic [7:0]  eight_bit_imm_val;
  logic [11:0] jump_address_input;
  logic [15:0] alu_result;
  logic        increment_ins_count;
  logic [1:0]  rd_addr_a;
  logic [1:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [11:0] pc;
  logic        write_done;
  logic        jump_done;
  logic        pc_reset_done;
  logic        illegal_op;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  execute_responder dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_opcode         (req_opcode),
    .store_at           (store_at),
    .reg_to_work_on     (reg_to_work_on),
    .eight_bit_imm_val  (eight_bit_imm_val),
    .jump_address_input (jump_address_input),
    .alu_result         (alu_result),
    .increment_ins_count(increment_ins_count),
    .rd_addr_a          (rd_addr_a),
    .rd_addr_b          (rd_addr_b),
    .rd_data_a          (rd_data_a),
    .rd_data_b          (rd_data_b),
    .pc                 (pc),
    .write_done         (write_done),
    .jump_done          (jump_done),
    .pc_reset_done      (pc_reset_done),
    .illegal_op         (illegal_op),
    .halted             (halted)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [1:0]  dst;
    logic [1:0]  del;
    logic [7:0]  imm;
    logic [11:0] jaddr;
    logic [15:0] alu;
    logic        inc_on_exec;
    logic [1:0]  chk_reg;
    logic [15:0] old_val;
    logic [15:0] new_val;
    logic [11:0] exp_pc;
    logic [3:0]  exp_pulses;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {write_done, jump_done, pc_reset_done, illegal_op};
  endfunction

  task automatic apply(input vec_t v);
    int extra;
    req_opcode         = v.op;
    store_at           = v.dst;
    reg_to_work_on     = v.del;
    eight_bit_imm_val  = v.imm;
    jump_address_input = v.jaddr;
    alu_result         = v.alu;
    rd_addr_a          = v.chk_reg;
    rd_addr_b          = v.chk_reg;
    req_valid          = 1'b1;
    @(posedge clk); #1;
    check({v.name, " pre-commit rd"}, rd_data_a, v.old_val);
    check({v.name, " pre-commit pulses"}, pulses(), 4'b0);
    if (v.inc_on_exec) increment_ins_count = 1'b1;
    @(posedge clk); #1;
    increment_ins_count = 1'b0;
    check({v.name, " pulses"}, pulses(), v.exp_pulses);
    check({v.name, " rd_a"}, rd_data_a, v.new_val);
    check({v.name, " rd_b"}, rd_data_b, v.new_val);
    check({v.name, " pc"}, pc, v.exp_pc);
    @(posedge clk); #1;
    check({v.name, " pulse width"}, pulses(), 4'b0);
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (pulses() != 4'b0) extra++;
    end
    check({v.name, " no re-exec"}, extra, 0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] op,
                              input logic [1:0] dst, input logic [1:0] del,
                              input logic [7:0] imm, input logic [11:0] ja,
                              input logic [15:0] alu, input logic inc,
                              input logic [1:0] cr, input logic [15:0] ov,
                              input logic [15:0] nv, input logic [11:0] ep,
                              input logic [3:0] epl);
    vec_t v;
    v.name = nm; v.op = op; v.dst = dst; v.del = del; v.imm = imm;
    v.jaddr = ja; v.alu = alu; v.inc_on_exec = inc; v.chk_reg = cr;
    v.old_val = ov; v.new_val = nv; v.exp_pc = ep; v.exp_pulses = epl;
    return v;
  endfunction

  initial begin
    int extra;
    reset = 1'b1;
    req_valid = 1'b0;
    req_opcode = '0;
    store_at = '0;
    reg_to_work_on = '0;
    eight_bit_imm_val = '0;
    jump_address_input = '0;
    alu_result = '0;
    increment_ins_count = 1'b0;
    rd_addr_a = 2'd2;
    rd_addr_b = 2'd1;

    vecs[0] = mk("storei r2", 4'b1000, 2'd2, 2'd0, 8'hA5, 12'h0,
                 16'h0, 1'b0, 2'd2, 16'h0000, 16'h00A5, 12'h000, 4'b1000);
    vecs[1] = mk("add r1", 4'b0000, 2'd1, 2'd0, 8'h00, 12'h0,
                 16'hFFFF, 1'b0, 2'd1, 16'h0000, 16'hFFFF, 12'h000, 4'b1000);
    vecs[2] = mk("delete r1", 4'b1010, 2'd3, 2'd1, 8'h77, 12'h0,
                 16'h5555, 1'b0, 2'd1, 16'hFFFF, 16'h0000, 12'h000, 4'b1000);
    vecs[3] = mk("storei r3", 4'b1000, 2'd3, 2'd0, 8'h7E, 12'h0,
                 16'h0, 1'b0, 2'd3, 16'h0000, 16'h007E, 12'h000, 4'b1000);
    vecs[4] = mk("add r0", 4'b0000, 2'd0, 2'd0, 8'h00, 12'h0,
                 16'h1234, 1'b0, 2'd0, 16'h0000, 16'h1234, 12'h000, 4'b1000);
    vecs[5] = mk("jump+inc", 4'b1001, 2'd0, 2'd0, 8'h00, 12'h7F0,
                 16'h0, 1'b1, 2'd0, 16'h1234, 16'h1234, 12'h7F0, 4'b0100);
    vecs[6] = mk("illegal", 4'b0101, 2'd2, 2'd2, 8'h00, 12'h123,
                 16'hBEEF, 1'b0, 2'd2, 16'h00A5, 16'h00A5, 12'h7F0, 4'b0001);

    repeat (3) @(posedge clk);
    #1;
    check("reset pc", pc, 12'h000);
    check("reset halted", halted, 1'b0);
    check("reset pulses", pulses(), 4'b0);
    check("reset rd_a", rd_data_a, 16'h0);
    check("reset rd_b", rd_data_b, 16'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) apply(vecs[i]);

    // pc wrap with a held increment level
    apply(mk("jump fff", 4'b1001, 2'd0, 2'd0, 8'h00, 12'hFFF, 16'h0,
             1'b0, 2'd0, 16'h1234, 16'h1234, 12'hFFF, 4'b0100));
    increment_ins_count = 1'b1;
    @(posedge clk); #1;
    check("wrap pc", pc, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    check("held inc pc", pc, 12'h000);
    increment_ins_count = 1'b0;
    @(posedge clk); #1;
    increment_ins_count = 1'b1;
    @(posedge clk); #1;
    check("second inc pc", pc, 12'h001);
    increment_ins_count = 1'b0;
    @(posedge clk); #1;

    // reset during EXEC discards the store
    apply(mk("storei r3 55", 4'b1000, 2'd3, 2'd0, 8'h55, 12'h0, 16'h0,
             1'b0, 2'd3, 16'h007E, 16'h0055, 12'h001, 4'b1000));
    eight_bit_imm_val = 8'h99;
    req_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    check("rst-exec write_done", write_done, 1'b0);
    check("rst-exec rf3", rd_data_a, 16'h0000);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (write_done) extra++;
    end
    check("rst-exec no late done", extra, 0);

    // HALT beats a same-edge increment and locks the unit
    apply(mk("storei r2 3c", 4'b1000, 2'd2, 2'd0, 8'h3C, 12'h0, 16'h0,
             1'b0, 2'd2, 16'h0000, 16'h003C, 12'h000, 4'b1000));
    apply(mk("jump 123", 4'b1001, 2'd0, 2'd0, 8'h00, 12'h123, 16'h0,
             1'b0, 2'd2, 16'h003C, 16'h003C, 12'h123, 4'b0100));
    apply(mk("halt", 4'b1111, 2'd0, 2'd0, 8'h00, 12'h0, 16'h0,
             1'b1, 2'd2, 16'h003C, 16'h003C, 12'h000, 4'b0010));
    check("halted set", halted, 1'b1);
    req_opcode = 4'b1000;
    store_at = 2'd2;
    eight_bit_imm_val = 8'h11;
    req_valid = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      increment_ins_count = i[0];
      @(posedge clk); #1;
      if (pulses() != 4'b0) extra++;
    end
    req_valid = 1'b0;
    increment_ins_count = 1'b0;
    check("halted no pulses", extra, 0);
    check("halted rf2", rd_data_a, 16'h003C);
    check("halted pc", pc, 12'h000);
    check("halted sticky", halted, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post-reset halted", halted, 1'b0);
    check("post-reset rf2", rd_data_a, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
